// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_pkg: shared state, ALU, opcode/funct and mux-select encodings for the multicycle MIPS controller
package mips_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP,
        HALT
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_BEQ = 4'd7;
    localparam logic [3:0] ALU_BNE = 4'd8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] IMM_SEXT     = 2'd0;
    localparam logic [1:0] IMM_FOUR     = 2'd1;
    localparam logic [1:0] IMM_SEXT_SH2 = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       alu_a_sel;
        logic [1:0] imm_sel;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal_op;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: request/ready handshake to the shared instruction/data memory port
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;
    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: R-type funct field to ALU operation, flagging unsupported funct codes
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       legal
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLL:  alu_ctrl = ALU_SLL;
            FN_SRL:  alu_ctrl = ALU_SRL;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM driving datapath selects and the memory handshake.
// Define MIPS_ILLEGAL_TRAP_EN to trap illegal instructions in HALT instead of retiring them as NOPs.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [5:0]                    opcode,
    input  logic [5:0]                    funct,
    input  logic                          zero,
    mips_multicycle_ctrl_if.master        mem,
    output logic                          iord,
    output logic                          ir_write,
    output logic                          pc_write,
    output logic [1:0]                    pc_src,
    output logic [3:0]                    alu_ctrl,
    output logic                          alu_src,
    output logic                          alu_a_sel,
    output logic [1:0]                    imm_sel,
    output logic                          reg_write,
    output logic                          reg_dst,
    output logic                          mem_to_reg,
    output logic                          instr_done,
    output logic                          illegal_op,
    output logic                          halted
);
`ifdef MIPS_ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = HALT;
`else
    localparam state_t ILL_NEXT = FETCH;
`endif

    state_t     state, state_n, dec_state;
    ctrl_t      c;
    logic [3:0] r_alu;
    logic       r_legal;
    logic       ill;

    mips_alu_decoder u_dec (
        .funct    (funct),
        .alu_ctrl (r_alu),
        .legal    (r_legal)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= RESET_STATE_FETCH ? FETCH : IDLE;
        else       state <= state_n;

    always_comb begin
        ill = !(opcode == OP_LW || opcode == OP_SW || (opcode == OP_RTYPE && r_legal) ||
                opcode == OP_BEQ || opcode == OP_BNE || opcode == OP_ADDI || opcode == OP_J);
        dec_state = ill ? ILL_NEXT :
                    (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                    opcode == OP_RTYPE ? EXEC :
                    (opcode == OP_BEQ || opcode == OP_BNE) ? BRANCH :
                    opcode == OP_ADDI ? ADDIEX : JUMP;
    end

    always_comb begin
        c       = '0;
        state_n = state;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_a_sel = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_sel   = IMM_FOUR;
                c.pc_src    = PC_ALU;
                c.ir_write  = mem.mem_ready;
                c.pc_write  = mem.mem_ready;
                state_n     = mem.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // speculative branch target lands in ALUOut while the opcode is decoded
                c.alu_a_sel  = 1'b1;
                c.alu_src    = 1'b1;
                c.imm_sel    = IMM_SEXT_SH2;
                c.illegal_op = ill;
`ifndef MIPS_ILLEGAL_TRAP_EN
                c.instr_done = ill;
`endif
                state_n      = dec_state;
            end
            MEMADR: begin
                c.alu_src = 1'b1;
                c.imm_sel = IMM_SEXT;
                state_n   = opcode == OP_SW ? MEMWR : MEMRD;
            end
            MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                state_n   = mem.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
                state_n      = FETCH;
            end
            MEMWR: begin
                c.mem_req    = 1'b1;
                c.mem_we     = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = mem.mem_ready;
                state_n      = mem.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                c.alu_ctrl = r_alu;
                state_n    = ALUWB;
            end
            ALUWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
                state_n      = FETCH;
            end
            BRANCH: begin
                c.alu_ctrl   = opcode == OP_BNE ? ALU_BNE : ALU_BEQ;
                c.pc_src     = PC_ALUOUT;
                c.pc_write   = zero;
                c.instr_done = 1'b1;
                state_n      = FETCH;
            end
            ADDIEX: begin
                c.alu_src = 1'b1;
                c.imm_sel = IMM_SEXT;
                state_n   = ADDIWB;
            end
            ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
                state_n      = FETCH;
            end
            JUMP: begin
                c.pc_src     = PC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
                state_n      = FETCH;
            end
`ifdef MIPS_ILLEGAL_TRAP_EN
            HALT: begin
                c.halted = 1'b1;
                state_n  = HALT;
            end
`endif
            default: state_n = FETCH;
        endcase
        if (reset) c = '0;
    end

    assign mem.mem_req = c.mem_req;
    assign mem.mem_we  = c.mem_we;
    assign iord        = c.iord;
    assign ir_write    = c.ir_write;
    assign pc_write    = c.pc_write;
    assign pc_src      = c.pc_src;
    assign alu_ctrl    = c.alu_ctrl;
    assign alu_src     = c.alu_src;
    assign alu_a_sel   = c.alu_a_sel;
    assign imm_sel     = c.imm_sel;
    assign reg_write   = c.reg_write;
    assign reg_dst     = c.reg_dst;
    assign mem_to_reg  = c.mem_to_reg;
    assign instr_done  = c.instr_done;
    assign illegal_op  = c.illegal_op;
    assign halted      = c.halted;

    a_we_with_req: assert property (@(posedge clk) disable iff (reset) mem.mem_we |-> mem.mem_req);
    a_done_onecycle: assert property (@(posedge clk) disable iff (reset) instr_done |=> state == FETCH || state == IDLE);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: random instruction stream with a memory responder, reference model and retirement scoreboard
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       iord, ir_write, pc_write, alu_src, alu_a_sel;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal_op, halted;
    logic [1:0] pc_src, imm_sel;
    logic [3:0] alu_ctrl;

    mips_multicycle_ctrl_if mem();

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem        (mem),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_ctrl   (alu_ctrl),
        .alu_src    (alu_src),
        .alu_a_sel  (alu_a_sel),
        .imm_sel    (imm_sel),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    wire [20:0] outs = {mem.mem_req, mem.mem_we, iord, ir_write, pc_write, pc_src, alu_ctrl, alu_src,
                        alu_a_sel, imm_sel, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op, halted};

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         fw;
        int         dw;
    } stim_t;

    typedef struct {
        int lat, dreq, we, rw, dst, m2r, pcw, ill, aluc, pcsrc;
    } exp_t;

    localparam int N = 300;

    exp_t  exp_q[$];
    stim_t cur;
    int    checks = 0, errors = 0, issued = 0, wcnt = 0;
    bit    sb_on = 0, done = 0, in_fetch = 0, in_data = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int r_alu(input logic [5:0] f);
        case (f)
            6'd32:   return 0;
            6'd34:   return 1;
            6'd36:   return 2;
            6'd37:   return 3;
            6'd0:    return 4;
            6'd2:    return 5;
            6'd42:   return 6;
            default: return -1;
        endcase
    endfunction

    function automatic bit known_op(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43};
    endfunction

    // cycle count is the sum of the phases the instruction walks through
    function automatic exp_t model(input stim_t s);
        exp_t e = '{default: 0};
        int   ac = r_alu(s.fn);
        e.lat = (1 + s.fw) + 1;
        e.pcw = 1;
        case (s.op)
            6'd35: begin e.lat += 1 + (1 + s.dw) + 1; e.dreq = 1 + s.dw; e.rw = 1; e.m2r = 1; end
            6'd43: begin e.lat += 1 + (1 + s.dw); e.dreq = 1 + s.dw; e.we = 1 + s.dw; end
            6'd0:  if (ac >= 0) begin e.lat += 2; e.rw = 1; e.dst = 1; e.aluc = ac; end
                   else e.ill = 1;
            6'd4, 6'd5: begin
                e.lat += 1; e.aluc = s.op == 6'd4 ? 7 : 8; e.pcw += int'(s.z); e.pcsrc = s.z ? 1 : 0;
            end
            6'd8:  begin e.lat += 2; e.rw = 1; end
            6'd2:  begin e.lat += 1; e.pcw = 2; e.pcsrc = 2; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic stim_t gen();
        stim_t      s;
        logic [5:0] lf[7];
        int         k;
        lf   = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd0, 6'd2, 6'd42};
        s.fn = lf[$urandom_range(0, 6)];
        s.z  = 1'($urandom_range(0, 1));
        s.fw = int'($urandom_range(0, 2));
        s.dw = int'($urandom_range(0, 3));
`ifdef MIPS_ILLEGAL_TRAP_EN
        k = int'($urandom_range(0, 7));
`else
        k = int'($urandom_range(0, 9));
`endif
        case (k)
            0:       s.op = 6'd35;
            1:       s.op = 6'd43;
            2, 3:    s.op = 6'd0;
            4:       s.op = 6'd4;
            5:       s.op = 6'd5;
            6:       s.op = 6'd8;
            7:       s.op = 6'd2;
            8:       begin s.op = 6'd0; s.fn = 6'($urandom); end
            default: begin s.op = 6'($urandom); while (known_op(s.op)) s.op = 6'($urandom); end
        endcase
        return s;
    endfunction

    // memory responder and instruction issue, evaluated just after each rising edge
    task automatic drive_cycle();
        if (mem.mem_req && !iord && !in_fetch) begin
            if (issued == N) begin
                done = 1;
                mem.mem_ready = 1'b0;
                return;
            end
            cur    = gen();
            opcode = cur.op;
            funct  = cur.fn;
            zero   = cur.z;
            exp_q.push_back(model(cur));
            issued++;
            in_fetch = 1;
            wcnt     = cur.fw;
        end
        if (mem.mem_req && iord && !in_data) begin
            in_data = 1;
            wcnt    = cur.dw;
        end
        mem.mem_ready = mem.mem_req ? (wcnt == 0) : 1'($urandom_range(0, 1));
        if (mem.mem_req && wcnt != 0) wcnt--;
        if (mem.mem_req && mem.mem_ready) begin
            in_fetch = 0;
            in_data  = 0;
        end
    endtask

    initial begin
        int         lat = 0, dreq = 0, we = 0, rw = 0, pcw = 0, ill = 0;
        logic [3:0] aluc = 0;
        logic [1:0] pcs = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!sb_on || reset) begin
                lat = 0; dreq = 0; we = 0; rw = 0; pcw = 0; ill = 0; aluc = 0; pcs = 0;
            end else begin
                lat++;
                dreq += int'(mem.mem_req && iord);
                we   += int'(mem.mem_we);
                rw   += int'(reg_write);
                pcw  += int'(pc_write);
                ill  += int'(illegal_op);
                aluc |= alu_ctrl;
                if (pc_write) pcs |= pc_src;
                if (mem.mem_we) chk("we_needs_req", 32'(mem.mem_req), 1);
                if (instr_done) begin
                    chk("retire_pending", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("latency", lat, e.lat);
                        chk("data_req_cycles", dreq, e.dreq);
                        chk("write_cycles", we, e.we);
                        chk("reg_write_cycles", rw, e.rw);
                        chk("retire_reg_dst", 32'(reg_dst), e.dst);
                        chk("retire_mem_to_reg", 32'(mem_to_reg), e.m2r);
                        chk("pc_write_cycles", pcw, e.pcw);
                        chk("illegal_pulses", ill, e.ill);
                        chk("exec_alu_ctrl", 32'(aluc), e.aluc);
                        chk("pc_src", 32'(pcs), e.pcsrc);
                    end
                    lat = 0; dreq = 0; we = 0; rw = 0; pcw = 0; ill = 0; aluc = 0; pcs = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: time limit reached with %0d expected retirements pending", exp_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit seen;
        reset = 1'b1;
        mem.mem_ready = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", 32'(outs), 0);

        reset  = 1'b0;
        opcode = 6'd43;
        for (int i = 0; i < 20 && !mem.mem_we; i++) begin
            mem.mem_ready = !(mem.mem_req && iord);
            @(posedge clk);
            #1;
        end
        mem.mem_ready = 1'b0;
        chk("sw_reaches_memwr", 32'(mem.mem_we), 1);
        chk("memwr_holds_req", 32'(mem.mem_req), 1);
        #2 reset = 1'b1;
        #1;
        chk("reset_drops_req", 32'(mem.mem_req), 0);
        chk("reset_mid_outputs", 32'(outs), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("post_reset_fetch", 32'({mem.mem_req, iord, mem.mem_we, instr_done}), 32'b1000);

        sb_on = 1;
        while (!done) begin
            drive_cycle();
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        #1;
        chk("all_retired", exp_q.size(), 0);
        sb_on = 0;

`ifdef MIPS_ILLEGAL_TRAP_EN
        opcode = 6'h3f;
        seen   = 0;
        for (int i = 0; i < 10 && !halted; i++) begin
            mem.mem_ready = 1'b1;
            if (illegal_op) seen = 1;
            @(posedge clk);
            #1;
        end
        chk("trap_illegal_pulse", 32'(seen), 1);
        chk("trap_halted_only", 32'(outs), 1);
        for (int i = 0; i < 4; i++) begin
            mem.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("halt_holds", 32'(outs), 1);
        end
        reset = 1'b1;
        #1;
        chk("halt_reset_outputs", 32'(outs), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("halt_reset_fetch", 32'({mem.mem_req, halted}), 32'b10);
`else
        seen = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS control FSM: the initiator side of the ALU control interface. Decodes opcode/funct, sequences fetch/decode/execute/memory/writeback, drives the ALU op code and operand selects, and consumes the ALU Zero flag to resolve branches. Sits in the core between the instruction register and the datapath muxes, and handshakes with a single shared instruction/data memory port.

Parameters:
RESET_STATE_FETCH, 1, 1 = leave reset directly into FETCH; 0 = hold in IDLE for one cycle first.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU Zero flag (beq: equal; bne: not equal)
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier for mem_req
iord  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
alu_ctrl  out  4  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt, 7 beq, 8 bne
alu_src  out  1  0 = B register, 1 = immediate path
alu_a_sel  out  1  0 = A register, 1 = PC
imm_sel  out  2  0 = sign-ext imm, 1 = constant 4, 2 = sign-ext imm<<2
reg_write  out  1  register file write
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_op  out  1  one-cycle pulse on an unrecognised opcode/funct
halted  out  1  trap state indicator (see Optional Feature)

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- Reset: asynchronous. State becomes FETCH, or IDLE if RESET_STATE_FETCH=0. All outputs read 0 while reset is high. Reset asserted mid-request drops mem_req immediately, with no completion.
- Outputs are decoded from the state. pc_write, ir_write and instr_done are additionally qualified as stated below.
- FETCH: mem_req=1, iord=0, alu_a_sel=1, alu_src=1, imm_sel=1, alu_ctrl=add, pc_src=0. Wait here while mem_ready=0. In the cycle mem_ready=1: ir_write=1, pc_write=1, then go to DECODE.
- DECODE: alu_a_sel=1, alu_src=1, imm_sel=2, alu_ctrl=add (branch target into ALUOut). Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 with legal funct -> EXEC
  - 000100/000101 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - anything else: illegal
- R-type funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 000000 sll, 000010 srl, 101010 slt. Other funct values are illegal.
- MEMADR: alu_a_sel=0, alu_src=1, imm_sel=0, add. Then MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1; wait for mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1; on mem_ready, instr_done=1 -> FETCH.
- EXEC: alu_a_sel=0, alu_src=0, alu_ctrl from funct -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH: alu_a_sel=0, alu_src=0, alu_ctrl=7 (beq) or 8 (bne), pc_src=1, pc_write=zero (same cycle), instr_done=1 -> FETCH.
- ADDIEX: alu_a_sel=0, alu_src=1, imm_sel=0, add -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- JUMP: pc_src=2, pc_write=1, instr_done=1 -> FETCH.
- Illegal opcode/funct: illegal_op pulses in DECODE, then per Optional Feature.
- Latency with zero-wait memory: R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3 cycles. Each memory wait cycle adds 1.
- mem_ready is ignored whenever mem_req=0. mem_we=1 only ever occurs together with mem_req=1.

Optional Feature:
- Macro: MIPS_ILLEGAL_TRAP_EN.
- Defined: illegal op -> HALT. HALT holds halted=1 with all other outputs 0 until reset.
- Undefined: illegal op is a NOP -> FETCH with instr_done=1. halted is tied to 0 and HALT is unreachable.

Decomposition:
- Package mips_pkg holds:
  - state enum
  - alu_ctrl localparams (ALU_ADD..ALU_BNE, 4-bit)
  - opcode/funct localparams
  - pc_src and imm_sel encodings
- Sub-module mips_alu_decoder: combinational funct -> {alu_ctrl, legal}, reused by EXEC decoding.

Test Plan:
- add (opcode 0, funct 100000), mem_ready=1 every cycle -> states FETCH, DECODE, EXEC, ALUWB; alu_ctrl=0 in EXEC; reg_write=1, reg_dst=1 in cycle 4; instr_done in cycle 4.
- lw with mem_ready low for 3 cycles in MEMRD -> mem_req held 4 cycles with iord=1; MEMWB reached once; total 8 cycles.
- beq with zero=1 -> alu_ctrl=7 and pc_write=1, pc_src=1 in BRANCH. Same instruction with zero=0 -> pc_write=0, instr_done=1.
- bne -> alu_ctrl=8 in BRANCH; zero=1 -> pc_write=1.
- opcode 111111 -> illegal_op pulse. With MIPS_ILLEGAL_TRAP_EN: halted=1, stays until reset. Without: returns to FETCH next cycle.
- reset asserted while in MEMWR with mem_req=1 -> mem_req=0 the same cycle. After release, FETCH with mem_req=1, no write completes.
